// File: rtl/core_inst_decoder_if.sv
// Core instruction bus bundle between the instruction source and the decoder.
// Single-cycle registered decode downstream, so the bus carries no handshake.
// No backpressure: a new instruction word may be presented every cycle.
//
// Ports (master = instruction source, slave = decoder):
//   inst[34:0]      packed instruction word (field map in core_inst_decoder.sv)
//   ofifo_valid     OFIFO holds a readable psum vector
//   err_clr         clears sticky error bits
//   xmem_*/pmem_*   SRAM chip enable, write enable (active-low) and address
//   l0_wr..bypass   decoded strobes
//   phase, drain_cnt, kij_cnt, pass_done, err   pass tracking and status
interface core_inst_decoder_if #(
  parameter int ADDR_W = 11
);
  logic [34:0]       inst;
  logic              ofifo_valid;
  logic              err_clr;

  logic              xmem_cen;
  logic              xmem_wen;
  logic [ADDR_W-1:0] xmem_addr;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [ADDR_W-1:0] pmem_addr;

  logic              l0_wr;
  logic              l0_rd;
  logic              ififo_wr;
  logic              ififo_rd;
  logic              ofifo_rd;
  logic              execute;
  logic              load;
  logic              acc;
  logic              bypass;

  logic [2:0]        phase;
  logic [5:0]        drain_cnt;
  logic [3:0]        kij_cnt;
  logic              pass_done;
  logic [3:0]        err;

  modport master (
    output inst, ofifo_valid, err_clr,
    input  xmem_cen, xmem_wen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
    input  l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load, acc, bypass,
    input  phase, drain_cnt, kij_cnt, pass_done, err
  );

  modport slave (
    input  inst, ofifo_valid, err_clr,
    output xmem_cen, xmem_wen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
    output l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load, acc, bypass,
    output phase, drain_cnt, kij_cnt, pass_done, err
  );
endinterface

// File: rtl/core_inst_decoder.sv
// Decodes the 35-bit core instruction into SRAM controls and corelet strobes, tracks pass phase.
// Latency: 1 cycle, every output is registered (inst sampled at edge N shows after edge N).
// No backpressure: accepts one instruction per cycle; illegal combinations are squashed and flagged.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active-low (0 = reset)
//   bus    core_inst_decoder_if.slave
//            in : inst, ofifo_valid, err_clr
//            out: xmem_cen/wen/addr, pmem_cen/wen/addr, l0_wr, l0_rd, ififo_wr, ififo_rd,
//                 ofifo_rd, execute, load, acc, bypass, phase, drain_cnt, kij_cnt, pass_done, err
//
// inst field map:
//   [34]bypass [33]acc [32]CEN_p [31]WEN_p [30:20]A_p [19]CEN_x [18]WEN_x [17:7]A_x
//   [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
// err bits (sticky): [0]CONFLICT [1]UNDERRUN [2]SHORT_DRAIN [3]PORT_CLASH
module core_inst_decoder #(
  parameter int ADDR_W  = 11,
  parameter int LEN_NIJ = 36,
  parameter int LEN_KIJ = 9
) (
  input  logic                clk,
  input  logic                reset,
  core_inst_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_XWR   = 3'd1,
    PH_LFILL = 3'd2,
    PH_KLOAD = 3'd3,
    PH_EXEC  = 3'd4,
    PH_DRAIN = 3'd5,
    PH_ACC   = 3'd6
  } phase_e;

  localparam logic [5:0] NIJ_CNT   = 6'(LEN_NIJ);
  localparam logic [3:0] KIJ_LAST  = 4'(LEN_KIJ - 1);
  localparam logic [5:0] DRAIN_MAX = 6'd63;

  // ---------------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------------
  logic              in_bypass;
  logic              in_acc;
  logic              in_cen_p;
  logic              in_wen_p;
  logic [ADDR_W-1:0] in_a_p;
  logic              in_cen_x;
  logic              in_wen_x;
  logic [ADDR_W-1:0] in_a_x;
  logic              in_ofifo_rd;
  logic              in_ififo_wr;
  logic              in_ififo_rd;
  logic              in_l0_rd;
  logic              in_l0_wr;
  logic              in_execute;
  logic              in_load;

  assign in_bypass   = bus.inst[34];
  assign in_acc      = bus.inst[33];
  assign in_cen_p    = bus.inst[32];
  assign in_wen_p    = bus.inst[31];
  assign in_a_p      = bus.inst[30:20];
  assign in_cen_x    = bus.inst[19];
  assign in_wen_x    = bus.inst[18];
  assign in_a_x      = bus.inst[17:7];
  assign in_ofifo_rd = bus.inst[6];
  assign in_ififo_wr = bus.inst[5];
  assign in_ififo_rd = bus.inst[4];
  assign in_l0_rd    = bus.inst[3];
  assign in_l0_wr    = bus.inst[2];
  assign in_execute  = bus.inst[1];
  assign in_load     = bus.inst[0];

  // ---------------------------------------------------------------------------
  // State / output registers
  // ---------------------------------------------------------------------------
  logic              xmem_cen_q,  xmem_cen_d;
  logic              xmem_wen_q,  xmem_wen_d;
  logic [ADDR_W-1:0] xmem_addr_q, xmem_addr_d;
  logic              pmem_cen_q,  pmem_cen_d;
  logic              pmem_wen_q,  pmem_wen_d;
  logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
  logic              l0_wr_q,     l0_wr_d;
  logic              l0_rd_q,     l0_rd_d;
  logic              ififo_wr_q,  ififo_wr_d;
  logic              ififo_rd_q,  ififo_rd_d;
  logic              ofifo_rd_q,  ofifo_rd_d;
  logic              execute_q,   execute_d;
  logic              load_q,      load_d;
  logic              acc_q,       acc_d;
  logic              bypass_q,    bypass_d;
  phase_e            phase_q,     phase_d;
  logic [5:0]        drain_q,     drain_d;
  logic [3:0]        kij_q,       kij_d;
  logic              pass_q,      pass_d;
  logic [3:0]        err_q,       err_d;

  // Decode intermediates
  logic x_wr;
  logic p_wr;
  logic conflict;
  logic underrun;
  logic clash_x;
  logic clash_p;
  logic stale_p;
  logic burst_end;
  logic short_drain;

  // ---------------------------------------------------------------------------
  // Next-state and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    x_wr        = ~in_cen_x & ~in_wen_x;
    p_wr        = ~in_cen_p & ~in_wen_p;
    conflict    = in_load & in_execute;
    underrun    = in_ofifo_rd & ~bus.ofifo_valid;
    clash_x     = x_wr & in_l0_wr;
    clash_p     = p_wr & in_acc & ~in_bypass;
    // A bypass write with no OFIFO data behind it would store a stale psum:
    // drop the whole pmem access, not just the write enable.
    stale_p     = underrun & in_bypass & p_wr;

    // SRAM controls: pass through, clashes keep the chip enabled but block the write.
    xmem_cen_d  = in_cen_x;
    xmem_wen_d  = in_wen_x | clash_x;
    xmem_addr_d = in_a_x;
    pmem_cen_d  = in_cen_p | stale_p;
    pmem_wen_d  = in_wen_p | stale_p | clash_p;
    pmem_addr_d = in_a_p;

    l0_wr_d     = in_l0_wr;
    l0_rd_d     = in_l0_rd;
    ififo_wr_d  = in_ififo_wr;
    ififo_rd_d  = in_ififo_rd;
    ofifo_rd_d  = in_ofifo_rd & bus.ofifo_valid;
    execute_d   = in_execute & ~conflict;
    load_d      = in_load & ~conflict;
    acc_d       = in_acc;
    bypass_d    = in_bypass;

    // Phase follows the raw request fields, so a drain with a momentary
    // underrun still counts as DRAIN and does not end the burst early.
    phase_d = PH_IDLE;
    if (in_acc)              phase_d = PH_ACC;
    else if (in_ofifo_rd)    phase_d = PH_DRAIN;
    else if (in_execute)     phase_d = PH_EXEC;
    else if (in_load)        phase_d = PH_KLOAD;
    else if (in_l0_wr)       phase_d = PH_LFILL;
    else if (x_wr)           phase_d = PH_XWR;

    // Burst bookkeeping: evaluated on the edge where phase leaves DRAIN.
    burst_end   = (phase_q == PH_DRAIN) && (phase_d != PH_DRAIN);
    short_drain = 1'b0;
    drain_d     = drain_q;
    kij_d       = kij_q;
    pass_d      = 1'b0;

    if (burst_end) begin
      drain_d = 6'd0;
      if (drain_q == NIJ_CNT) begin
        if (kij_q == KIJ_LAST) begin
          kij_d  = 4'd0;
          pass_d = 1'b1;
        end else begin
          kij_d = kij_q + 4'd1;
        end
      end else begin
        short_drain = 1'b1;
      end
    end else if (ofifo_rd_d && (drain_q != DRAIN_MAX)) begin
      drain_d = drain_q + 6'd1;
    end

    // Sticky errors; a new event in the clearing cycle survives the clear.
    err_d = (bus.err_clr ? 4'd0 : err_q)
          | {(clash_x | clash_p), short_drain, underrun, conflict};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xmem_cen_q  <= 1'b1;
      xmem_wen_q  <= 1'b1;
      xmem_addr_q <= '0;
      pmem_cen_q  <= 1'b1;
      pmem_wen_q  <= 1'b1;
      pmem_addr_q <= '0;
      l0_wr_q     <= 1'b0;
      l0_rd_q     <= 1'b0;
      ififo_wr_q  <= 1'b0;
      ififo_rd_q  <= 1'b0;
      ofifo_rd_q  <= 1'b0;
      execute_q   <= 1'b0;
      load_q      <= 1'b0;
      acc_q       <= 1'b0;
      bypass_q    <= 1'b0;
      phase_q     <= PH_IDLE;
      drain_q     <= 6'd0;
      kij_q       <= 4'd0;
      pass_q      <= 1'b0;
      err_q       <= 4'd0;
    end else begin
      xmem_cen_q  <= xmem_cen_d;
      xmem_wen_q  <= xmem_wen_d;
      xmem_addr_q <= xmem_addr_d;
      pmem_cen_q  <= pmem_cen_d;
      pmem_wen_q  <= pmem_wen_d;
      pmem_addr_q <= pmem_addr_d;
      l0_wr_q     <= l0_wr_d;
      l0_rd_q     <= l0_rd_d;
      ififo_wr_q  <= ififo_wr_d;
      ififo_rd_q  <= ififo_rd_d;
      ofifo_rd_q  <= ofifo_rd_d;
      execute_q   <= execute_d;
      load_q      <= load_d;
      acc_q       <= acc_d;
      bypass_q    <= bypass_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      kij_q       <= kij_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.xmem_cen  = xmem_cen_q;
  assign bus.xmem_wen  = xmem_wen_q;
  assign bus.xmem_addr = xmem_addr_q;
  assign bus.pmem_cen  = pmem_cen_q;
  assign bus.pmem_wen  = pmem_wen_q;
  assign bus.pmem_addr = pmem_addr_q;
  assign bus.l0_wr     = l0_wr_q;
  assign bus.l0_rd     = l0_rd_q;
  assign bus.ififo_wr  = ififo_wr_q;
  assign bus.ififo_rd  = ififo_rd_q;
  assign bus.ofifo_rd  = ofifo_rd_q;
  assign bus.execute   = execute_q;
  assign bus.load      = load_q;
  assign bus.acc       = acc_q;
  assign bus.bypass    = bypass_q;
  assign bus.phase     = phase_q;
  assign bus.drain_cnt = drain_q;
  assign bus.kij_cnt   = kij_q;
  assign bus.pass_done = pass_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_core_inst_decoder.sv
// Scoreboard bench for core_inst_decoder: directed vectors push expected outputs,
// a monitor pops and compares one cycle after each vector is sampled.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_core_inst_decoder;

  logic clk;
  logic reset;

  core_inst_decoder_if #(.ADDR_W(11)) bus ();

  core_inst_decoder #(.ADDR_W(11), .LEN_NIJ(36), .LEN_KIJ(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stb = {l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load, acc, bypass}
  typedef struct packed {
    logic        xc;
    logic        xw;
    logic [10:0] xa;
    logic        pc;
    logic        pw;
    logic [10:0] pa;
    logic [8:0]  stb;
    logic [2:0]  ph;
    logic [5:0]  dc;
    logic [3:0]  kc;
    logic        pd;
    logic [3:0]  er;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic logic [34:0] mk(input logic byp, input logic acc, input logic cp,
                                     input logic wp, input logic [10:0] ap, input logic cx,
                                     input logic wx, input logic [10:0] ax, input logic [6:0] lo);
    return {byp, acc, cp, wp, ap, cx, wx, ax, lo};
  endfunction

  // Idle instruction and the matching quiescent output (same as the reset values).
  function automatic logic [34:0] idle_i();
    return mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0);
  endfunction

  function automatic exp_t idle_e(input logic [5:0] dc, input logic [3:0] kc,
                                  input logic pd, input logic [3:0] er);
    exp_t e;
    e.xc = 1'b1; e.xw = 1'b1; e.xa = 11'd0;
    e.pc = 1'b1; e.pw = 1'b1; e.pa = 11'd0;
    e.stb = 9'd0; e.ph = 3'd0;
    e.dc = dc; e.kc = kc; e.pd = pd; e.er = er;
    return e;
  endfunction

  task automatic vec(input logic rst, input logic [34:0] i, input logic ov, input logic clr,
                     input exp_t e, input string nm);
    @(negedge clk);
    reset           = rst;
    bus.inst        = i;
    bus.ofifo_valid = ov;
    bus.err_clr     = clr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // 36 bypass drain cycles writing pmem addr i; cycles flagged in bad_mask have no OFIFO data.
  // Followed by one idle cycle whose expected counters/err are supplied by the caller.
  task automatic drain_burst(input logic [3:0] kc, input logic [35:0] bad_mask,
                             input logic [3:0] er_in, input logic [3:0] kc_after,
                             input logic pd_after, input logic [3:0] er_after, input string nm);
    exp_t       e;
    logic [5:0] cnt;
    logic [3:0] er;
    logic       ov;
    cnt = 6'd0;
    er  = er_in;
    for (int i = 0; i < 36; i++) begin
      ov = ~bad_mask[i];
      if (ov) cnt = cnt + 6'd1;
      else    er  = er | 4'b0010;
      e     = idle_e(cnt, kc, 1'b0, er);
      e.pc  = ~ov;
      e.pw  = ~ov;
      e.pa  = 11'(i);
      e.stb = {4'b0000, ov, 3'b000, 1'b1};
      e.ph  = 3'd5;
      vec(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 11'(i), 1'b1, 1'b1, 11'd0, 7'b1000000), ov, 1'b0, e, nm);
    end
    vec(1'b1, idle_i(), 1'b0, 1'b0, idle_e(6'd0, kc_after, pd_after, er_after), {nm, "_end"});
  endtask

  // Monitor / scoreboard
  exp_t  m_exp;
  exp_t  m_act;
  string m_nm;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_nm  = name_q.pop_front();
      m_act = {bus.xmem_cen, bus.xmem_wen, bus.xmem_addr, bus.pmem_cen, bus.pmem_wen,
               bus.pmem_addr, bus.l0_wr, bus.l0_rd, bus.ififo_wr, bus.ififo_rd, bus.ofifo_rd,
               bus.execute, bus.load, bus.acc, bus.bypass, bus.phase, bus.drain_cnt,
               bus.kij_cnt, bus.pass_done, bus.err};
      n_vec++;
      if (m_act !== m_exp) begin
        n_bad++;
        $display("FAIL %s: got xc/xw=%b%b xa=%h pc/pw=%b%b pa=%h stb=%b ph=%0d dc=%0d kc=%0d pd=%b err=%b | want xc/xw=%b%b xa=%h pc/pw=%b%b pa=%h stb=%b ph=%0d dc=%0d kc=%0d pd=%b err=%b",
                 m_nm, m_act.xc, m_act.xw, m_act.xa, m_act.pc, m_act.pw, m_act.pa, m_act.stb,
                 m_act.ph, m_act.dc, m_act.kc, m_act.pd, m_act.er,
                 m_exp.xc, m_exp.xw, m_exp.xa, m_exp.pc, m_exp.pw, m_exp.pa, m_exp.stb,
                 m_exp.ph, m_exp.dc, m_exp.kc, m_exp.pd, m_exp.er);
      end
    end
  end

  initial begin
    logic [63:0] rnd;
    exp_t        e;

    reset           = 1'b0;
    bus.inst        = '0;
    bus.ofifo_valid = 1'b0;
    bus.err_clr     = 1'b0;

    // 1. Reset held with random instructions -> reset values.
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom(), $urandom()};
      vec(1'b0, rnd[34:0], rnd[40], rnd[41], idle_e(6'd0, 4'd0, 1'b0, 4'd0), "reset_hold");
    end
    // Release: first instruction decoded one cycle later (xmem write + l0_rd -> XWR).
    e = idle_e(6'd0, 4'd0, 1'b0, 4'd0);
    e.xc = 1'b0; e.xw = 1'b0; e.xa = 11'h123; e.stb = 9'b010000000; e.ph = 3'd1;
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 11'h123, 7'b0001000), 1'b0, 1'b0, e,
        "first_decode");
    vec(1'b1, idle_i(), 1'b0, 1'b0, idle_e(6'd0, 4'd0, 1'b0, 4'd0), "idle0");

    // 2/3. Nine full bursts: kij 0..8, wrap to 0 with a single pass_done pulse.
    for (int k = 0; k < 9; k++) begin
      drain_burst(4'(k), 36'd0, 4'd0, (k == 8) ? 4'd0 : 4'(k + 1), (k == 8), 4'd0, "drain");
    end
    vec(1'b1, idle_i(), 1'b0, 1'b0, idle_e(6'd0, 4'd0, 1'b0, 4'd0), "pass_pulse_off");

    // One more full burst so the underrun case can show kij being held at 1.
    drain_burst(4'd0, 36'd0, 4'd0, 4'd1, 1'b0, 4'd0, "drain_k0b");

    // 4. Underrun on cycles 10 and 20 -> 34 reads, err=0110, kij held.
    drain_burst(4'd1, (36'd1 << 10) | (36'd1 << 20), 4'd0, 4'd1, 1'b0, 4'b0110, "underrun");
    vec(1'b1, idle_i(), 1'b0, 1'b1, idle_e(6'd0, 4'd1, 1'b0, 4'd0), "err_clr_underrun");

    // 5. Conflict: load and execute both squashed, phase EXEC.
    e = idle_e(6'd0, 4'd1, 1'b0, 4'b0001); e.ph = 3'd4;
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000011), 1'b0, 1'b0, e,
        "conflict");
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000011), 1'b0, 1'b1, e,
        "conflict_vs_clr");
    vec(1'b1, idle_i(), 1'b0, 1'b1, idle_e(6'd0, 4'd1, 1'b0, 4'd0), "err_clr_conflict");
    e = idle_e(6'd0, 4'd1, 1'b0, 4'd0); e.stb = 9'b000000100; e.ph = 3'd3;
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000001), 1'b0, 1'b0, e,
        "load_only");
    e = idle_e(6'd0, 4'd1, 1'b0, 4'd0); e.stb = 9'b000001000; e.ph = 3'd4;
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000010), 1'b0, 1'b0, e,
        "exec_only");

    // 6. Port clash: xmem write with l0_wr -> write blocked, LFILL, err[3].
    e = idle_e(6'd0, 4'd1, 1'b0, 4'b1000);
    e.xc = 1'b0; e.xw = 1'b1; e.xa = 11'h055; e.stb = 9'b100000000; e.ph = 3'd2;
    vec(1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 11'h055, 7'b0000100), 1'b0, 1'b0, e,
        "clash_xmem");
    // pmem write with acc and no bypass -> write blocked, ACC.
    e = idle_e(6'd0, 4'd1, 1'b0, 4'b1000);
    e.pc = 1'b0; e.pw = 1'b1; e.pa = 11'h2AA; e.stb = 9'b000000010; e.ph = 3'd6;
    vec(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 11'h2AA, 1'b1, 1'b1, 11'd0, 7'd0), 1'b0, 1'b0, e,
        "clash_pmem");
    // acc with bypass writes normally; err stays sticky.
    e = idle_e(6'd0, 4'd1, 1'b0, 4'b1000);
    e.pc = 1'b0; e.pw = 1'b0; e.pa = 11'h077; e.stb = 9'b000000011; e.ph = 3'd6;
    vec(1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 11'h077, 1'b1, 1'b1, 11'd0, 7'd0), 1'b0, 1'b0, e,
        "acc_bypass_wr");
    vec(1'b1, idle_i(), 1'b0, 1'b1, idle_e(6'd0, 4'd1, 1'b0, 4'd0), "err_clr_clash");

    // Async reset mid-burst: counters cleared, no short-drain flag afterwards.
    for (int i = 0; i < 5; i++) begin
      e = idle_e(6'(i + 1), 4'd1, 1'b0, 4'd0);
      e.pc = 1'b0; e.pw = 1'b0; e.pa = 11'(i); e.stb = 9'b000010001; e.ph = 3'd5;
      vec(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 11'(i), 1'b1, 1'b1, 11'd0, 7'b1000000), 1'b1, 1'b0, e,
          "mid_drain");
    end
    vec(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd5, 1'b1, 1'b1, 11'd0, 7'b1000000), 1'b1, 1'b0,
        idle_e(6'd0, 4'd0, 1'b0, 4'd0), "mid_reset");
    vec(1'b1, idle_i(), 1'b0, 1'b0, idle_e(6'd0, 4'd0, 1'b0, 4'd0), "after_reset");

    // Let the monitor drain the scoreboard, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
